sid_i2s_tx: RTL



---
 rtl/sid_audio_pkg.sv | 17 +
 rtl/sid_i2s_clkgen.sv | 45 ++++
 rtl/sid_i2s_tx.sv | 98 +++++++++
 3 files changed

// File: rtl/sid_audio_pkg.sv
// Shared constants and sample-format helper for the SID audio output path.
package sid_audio_pkg;

  localparam int SAMPLE_W   = 12;
  localparam int WORD_W     = 16;
  localparam int SLOT_W     = 32;
  localparam int FRAME_BITS = 64;
  localparam int BIT_CNT_W  = $clog2(FRAME_BITS);
  localparam int SLOT_POS_W = $clog2(SLOT_W);
  localparam int WORD_IDX_W = $clog2(WORD_W);

  // Offset-binary to two's complement is an MSB flip; the 4 zero LSBs left-justify to 16 bits.
  function automatic logic [WORD_W-1:0] sid_to_pcm16(input logic [SAMPLE_W-1:0] s);
    return {~s[SAMPLE_W-1], s[SAMPLE_W-2:0], 4'b0000};
  endfunction

endpackage

// File: rtl/sid_i2s_clkgen.sv
// I2S bit-clock generator: system-clock divider, BCLK, frame bit counter and edge events.
module sid_i2s_clkgen
  import sid_audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  output logic                 bclk,
  output logic [BIT_CNT_W-1:0] bit_cnt,
  output logic                 rise,
  output logic                 fall,
  output logic                 frame_wrap
);

  localparam int DIV_W = (BCLK_DIV > 1) ? $clog2(BCLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BCLK_DIV - 1);

  logic [DIV_W-1:0] div_cnt;
  logic             wrap;

  assign wrap       = (div_cnt == DIV_LAST);
  assign rise       = wrap & ~bclk;
  assign fall       = wrap & bclk;
  assign frame_wrap = fall & (bit_cnt == '1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
      bit_cnt <= '0;
    end else begin
      if (wrap) begin
        div_cnt <= '0;
        bclk    <= ~bclk;
      end else begin
        div_cnt <= div_cnt + 1'b1;
      end
      if (fall) begin
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID 12-bit mono stream, duplicated on both channels.
// Optional build macro SID_I2S_AVG_EN: boxcar-average each frame period instead of point sampling.
module sid_i2s_tx
  import sid_audio_pkg::*;
#(
  parameter int BCLK_DIV = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] audio,
  input  logic                mute,
  output logic                i2s_bclk,
  output logic                i2s_lrclk,
  output logic                i2s_sdata,
  output logic                sample_strobe
);

  localparam logic [SLOT_POS_W-1:0] LAST_DATA_POS = SLOT_POS_W'(WORD_W);

  logic [BIT_CNT_W-1:0]  bit_cnt;
  logic [BIT_CNT_W-1:0]  bit_next;
  logic [SLOT_POS_W-1:0] slot_pos;
  logic [WORD_IDX_W-1:0] word_idx;
  logic                  fall;
  logic                  frame_wrap;
  logic                  rise_unused;
  logic [SAMPLE_W-1:0]   sample;
  logic [WORD_W-1:0]     word_reg;
  logic                  data_next;

  sid_i2s_clkgen #(
    .BCLK_DIV (BCLK_DIV)
  ) u_clkgen (
    .clk        (clk),
    .reset      (reset),
    .bclk       (i2s_bclk),
    .bit_cnt    (bit_cnt),
    .rise       (rise_unused),
    .fall       (fall),
    .frame_wrap (frame_wrap)
  );

`ifdef SID_I2S_AVG_EN
  localparam int LOG2_P = $clog2(2 * FRAME_BITS * BCLK_DIV);
  localparam int ACC_W  = SAMPLE_W + LOG2_P;

  if (BCLK_DIV < 2 || (BCLK_DIV & (BCLK_DIV - 1)) != 0) begin : g_bad_div
    $error("sid_i2s_tx: BCLK_DIV must be a power of two >= 2 when averaging");
  end

  logic [ACC_W-1:0] acc_reg;

  // The latch-cycle sample opens the next window, so every window is exactly one frame long.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_reg <= '0;
    end else if (frame_wrap) begin
      acc_reg <= ACC_W'(audio);
    end else begin
      acc_reg <= acc_reg + ACC_W'(audio);
    end
  end

  assign sample = acc_reg[ACC_W-1:LOG2_P];
`else
  assign sample = audio;
`endif

  // Outputs are computed for the bit position BCLK is about to fall into.
  always_comb begin
    bit_next  = bit_cnt + 1'b1;
    slot_pos  = bit_next[SLOT_POS_W-1:0];
    word_idx  = WORD_IDX_W'(LAST_DATA_POS - slot_pos);
    data_next = 1'b0;
    if (slot_pos != '0 && slot_pos <= LAST_DATA_POS) begin
      data_next = word_reg[word_idx];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      word_reg      <= '0;
      sample_strobe <= 1'b0;
      i2s_lrclk     <= 1'b0;
      i2s_sdata     <= 1'b0;
    end else begin
      sample_strobe <= frame_wrap;
      if (frame_wrap) begin
        word_reg <= mute ? '0 : sid_to_pcm16(sample);
      end
      if (fall) begin
        i2s_lrclk <= bit_next[BIT_CNT_W-1];
        i2s_sdata <= data_next;
      end
    end
  end

endmodule
